multi_mode_arbiter: RTL

//   Parametrised N-way arbiter: successor of the 4-way fixed-priority arbiter.
//   Two modes: fixed priority, with a programmable one-hot top requester, and round-robin.

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_rot_pick.sv | 28 ++
 rtl/multi_mode_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the multi-mode arbiter.
package arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Lowest set bit index, 0 when no bit is set.
    function automatic int unsigned onehot2idx(input logic [63:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_rot_pick.sv
// Combinational rotating picker: first set request at or above start, wrapping to 0.
module arb_rot_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_masked,
    input  logic [IDW-1:0] start,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_id,
    output logic           any
);

    always_comb begin
        pick    = '0;
        pick_id = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(start) + k) % N;
            if (!any && req_masked[idx]) begin
                pick[idx] = 1'b1;
                pick_id   = IDW'(idx);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_mode_arbiter.sv
// N-way arbiter with fixed-priority / round-robin modes and a grant tenure limit.
module multi_mode_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   priv,
    input  logic           mode,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] gnt_id,
    output logic           vld
);

    localparam int HCW = $clog2(MAX_HOLD + 1);

    arb_state_e     r_state, w_state_nxt;
    logic [N-1:0]   r_grant, w_grant_nxt;
    logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [HCW-1:0] r_hold_cnt, w_hold_nxt;
    logic [IDW-1:0] r_rr_ptr, w_rr_nxt;

    logic [N-1:0]   w_masked, w_pick;
    logic [IDW-1:0] w_start, w_pick_id, w_pick_succ;
    logic           w_any, w_own_req, w_expired;

    assign w_own_req = |(req & r_grant);
    assign w_expired = (r_hold_cnt >= HCW'(MAX_HOLD));
    // While busy the owner never competes: either it released, or its tenure ran out.
    assign w_masked  = (r_state == BUSY) ? (req & ~r_grant) : req;
    assign w_start   = (mode == ARB_RR) ? r_rr_ptr : IDW'(onehot2idx(64'(priv)));
    assign w_pick_succ = (w_pick_id == IDW'(N - 1)) ? '0 : w_pick_id + IDW'(1);

    arb_rot_pick #(.N(N), .IDW(IDW)) u_pick (
        .req_masked (w_masked),
        .start      (w_start),
        .pick       (w_pick),
        .pick_id    (w_pick_id),
        .any        (w_any)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gnt_id_nxt = r_gnt_id;
        w_hold_nxt   = r_hold_cnt;
        w_rr_nxt     = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = BUSY;
                    w_grant_nxt  = w_pick;
                    w_gnt_id_nxt = w_pick_id;
                    w_hold_nxt   = HCW'(1);
                    w_rr_nxt     = w_pick_succ;
                end
            end
            BUSY: begin
                if (w_own_req && !w_expired) begin
                    w_hold_nxt = r_hold_cnt + HCW'(1);
                end else if (w_any) begin
                    w_grant_nxt  = w_pick;
                    w_gnt_id_nxt = w_pick_id;
                    w_hold_nxt   = HCW'(1);
                    w_rr_nxt     = w_pick_succ;
                end else if (w_own_req) begin
                    // Sole requester at expiry: restart tenure without a gap.
                    w_hold_nxt = HCW'(1);
                end else begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_gnt_id_nxt = '0;
                    w_hold_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_grant_nxt  = '0;
                w_gnt_id_nxt = '0;
                w_hold_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_gnt_id   <= '0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rr_ptr   <= w_rr_nxt;
        end
    end

    assign grant  = r_grant;
    assign gnt_id = r_gnt_id;
    assign vld    = |r_grant;

endmodule
